// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
package mips_cpu_muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } md_state_e;

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mips_cpu_muldiv_step (
    input  logic        is_div_i,
    input  logic [31:0] upper_i,
    input  logic [31:0] lower_i,
    input  logic [31:0] operand_i,
    output logic [31:0] upper_o,
    output logic [31:0] lower_o
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    always_comb begin
        sum     = {1'b0, upper_i} + (lower_i[0] ? {1'b0, operand_i} : 33'd0);
        shifted = {upper_i, lower_i[31]};
        fits    = (shifted >= {1'b0, operand_i});
        // When the trial subtract fits, the true difference is below the divisor, so 32 bits suffice.
        diff    = shifted[31:0] - operand_i;
        if (is_div_i) begin
            upper_o = fits ? diff : shifted[31:0];
            lower_o = {lower_i[30:0], fits};
        end else begin
            upper_o = sum[32:1];
            lower_o = {sum[0], lower_i[31:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO unit: fixed-latency iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
module mips_cpu_muldiv #(
    parameter int ITER = mips_cpu_muldiv_pkg::ITER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import mips_cpu_muldiv_pkg::*;

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic        b_sign_q, b_sign_d;
    logic [31:0] upper_q, upper_d, lower_q, lower_d, opnd_q, opnd_d;
    logic [31:0] step_upper, step_lower;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        return v[31] ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic neg);
        return neg ? 64'(-v) : v;
    endfunction

    function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic neg);
        return neg ? 32'(-v) : v;
    endfunction

    mips_cpu_muldiv_step u_step (
        .is_div_i  (op_q == MD_DIV || op_q == MD_DIVU),
        .upper_i   (upper_q),
        .lower_i   (lower_q),
        .operand_i (opnd_q),
        .upper_o   (step_upper),
        .lower_o   (step_lower)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        a_d      = a_q;
        b_sign_d = b_sign_q;
        upper_d  = upper_q;
        lower_d  = lower_q;
        opnd_d   = opnd_q;
        prod     = {upper_q, lower_q};
        quo      = lower_q;
        rem      = upper_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            op_d     = op;
                            a_d      = a;
                            b_sign_d = b[31];
                            upper_d  = '0;
                            lower_d  = (op == MD_MULT || op == MD_DIV) ? mag32(a) : a;
                            opnd_d   = (op == MD_MULT || op == MD_DIV) ? mag32(b) : b;
                            cnt_d    = '0;
                            state_d  = ST_CALC;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                upper_d = step_upper;
                lower_d = step_lower;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1)) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (op_q == MD_MULT || op_q == MD_MULTU) begin
                    prod = neg_if64(prod, op_q == MD_MULT && (a_q[31] ^ b_sign_q));
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (opnd_q == '0) begin
                    // Divide by zero returns a fixed pattern rather than the iteration result.
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    quo  = neg_if32(quo, op_q == MD_DIV && (a_q[31] ^ b_sign_q));
                    rem  = neg_if32(rem, op_q == MD_DIV && a_q[31]);
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q     <= op_d;
        a_q      <= a_d;
        b_sign_q <= b_sign_d;
        upper_q  <= upper_d;
        lower_q  <= lower_d;
        opnd_q   <= opnd_d;
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk is the one clock, and reset is synchronous and active-high.
REQ-002 SHALL have ports:
  clk    in   1   rising-edge clock
  reset  in   1   synchronous active-high reset
  start  in   1   request; sampled each edge while idle
  op     in   3   operation code from shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO
  a      in   32  rs operand (dividend / multiplicand / move source)
  b      in   32  rt operand (divisor / multiplier)
  busy   out  1   high while an iterative operation is in flight
  done   out  1   one-cycle pulse; HI/LO just updated by MULT/MULTU/DIV/DIVU
  hi     out  32  architectural HI register
  lo     out  32  architectural LO register
REQ-003 SHALL take parameter ITER (default 32): number of iteration cycles, fixed at operand width.

Function
REQ-004 SHALL implement FSM states IDLE, CALC, FINISH; busy = (state != IDLE).
REQ-005 IDLE and start with MULT/MULTU/DIV/DIVU at edge E0: latch a, b, op; load operand magnitudes (signed ops) or raw values (unsigned ops); clear counter; go to CALC.
REQ-006 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; after the step at edge E32, go to FINISH.
REQ-007 FINISH at edge E33: apply sign fix-up; write hi/lo; register done=1 for exactly the following cycle; return to IDLE.
REQ-008 Total latency SHALL be fixed: start at E0 gives new hi/lo and done visible after E33, independent of operand values.
REQ-009 MULT/MULTU: {hi,lo} = 64-bit product; MULT sign-negates when a[31]^b[31].
REQ-010 DIV/DIVU: lo = quotient, hi = remainder; for DIV, quotient sign = a[31]^b[31] and remainder sign = a[31].
REQ-011 Divide by zero (b=0, DIV or DIVU): lo=0xFFFFFFFF, hi=a; same latency; no error output.
REQ-012 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-013 MTHI/MTLO with start in IDLE: write a into hi/lo at that edge; no busy, no done; the other register is unchanged.
REQ-014 start while busy SHALL be ignored, with no queuing and no state change; a, b, op changes during busy have no effect.
REQ-015 hi/lo SHALL hold their previous values throughout CALC; they change only at FINISH or on MTHI/MTLO.
REQ-016 Undefined op codes with start SHALL be ignored and leave the FSM in IDLE.
REQ-017 start at the same edge as done's cycle (the first IDLE cycle) SHALL be accepted normally.

Reset
REQ-018 reset at any edge, including mid-CALC or FINISH, SHALL force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and discard the in-flight operation.
REQ-019 reset SHALL override a simultaneous start.

Structure
REQ-020 SHALL place the op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO), the state enum, and ITER in package mips_cpu_muldiv_pkg.
REQ-021 SHALL use one sub-module, mips_cpu_muldiv_step: a combinational single-iteration datapath (add/shift for multiply, trial-subtract/shift for divide) instantiated once.

Verification
REQ-022 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-023 MULT a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for exactly 33 cycles.
REQ-024 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-025 MTHI a=0x12345678 while idle -> hi=0x12345678 next cycle, lo unchanged, busy/done stay 0; MTLO issued during busy -> ignored.
REQ-026 Start DIVU, assert reset at cycle 10 -> busy=0, hi=lo=0, no done pulse; a new MULTU started afterwards completes correctly.
